// File: rtl/riscv_wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its scoreboard.
package riscv_wb_arbiter_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } wb_state_e;

  function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
    return idx == REG_X0;
  endfunction

endpackage

// File: rtl/riscv_wb_scoreboard.sv
// Pending-destination mask for long-latency results plus the decode hazard lookups.
module riscv_wb_scoreboard
  import riscv_wb_arbiter_pkg::*;
#(
  parameter int unsigned N_REG = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_set_en,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic                 i_clr_en,
  input  logic [REG_IDX_W-1:0] i_clr_idx,
  input  logic [REG_IDX_W-1:0] i_rs1_d,
  input  logic [REG_IDX_W-1:0] i_rs2_d,
  input  logic [REG_IDX_W-1:0] i_rd_d,
  output logic                 o_stall_d
);

  logic [N_REG-1:0] mask_q, mask_d;

  // Clear first so a same-cycle set of the same index wins.
  always_comb begin
    mask_d = mask_q;
    if (i_clr_en) mask_d[i_clr_idx] = 1'b0;
    if (i_set_en && !is_x0(i_set_idx)) mask_d[i_set_idx] = 1'b1;
    mask_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  function automatic logic pending(input logic [REG_IDX_W-1:0] idx);
    return !is_x0(idx) && mask_q[idx];
  endfunction

  assign o_stall_d = pending(i_rs1_d) | pending(i_rs2_d) | pending(i_rd_d);

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and one long-latency unit.
// Optional same-cycle LU bypass when idle: define RISCV_WB_LU_BYPASS_EN.
module riscv_wb_arbiter
  import riscv_wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned N_REG        = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pipe_wb_valid,
  input  logic [REG_IDX_W-1:0] i_pipe_rd,
  input  logic [XLEN-1:0]      i_pipe_data,
  input  logic                 i_lu_issue,
  input  logic [REG_IDX_W-1:0] i_lu_issue_rd,
  input  logic                 i_lu_valid,
  output logic                 o_lu_ready,
  input  logic [REG_IDX_W-1:0] i_lu_rd,
  input  logic [XLEN-1:0]      i_lu_data,
  input  logic [REG_IDX_W-1:0] i_rs1_d,
  input  logic [REG_IDX_W-1:0] i_rs2_d,
  input  logic [REG_IDX_W-1:0] i_rd_d,
  output logic                 o_stall_d,
  output logic                 o_bubble_req,
  output logic                 o_rf_we,
  output logic [REG_IDX_W-1:0] o_rf_rd,
  output logic [XLEN-1:0]      o_rf_wdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic [REG_IDX_W-1:0]   buf_rd_q;
  logic [XLEN-1:0]        buf_data_q;
  logic                   buf_full, drain, accept, bypass, capture;

  assign buf_full   = (state_q != ST_IDLE);
  assign drain      = buf_full && !i_pipe_wb_valid;
  assign o_lu_ready = !buf_full || drain;
  assign accept     = i_lu_valid && o_lu_ready;
  assign cnt_inc    = cnt_q + CNT_W'(1);

`ifdef RISCV_WB_LU_BYPASS_EN
  assign bypass = !buf_full && i_lu_valid && !i_pipe_wb_valid;
`else
  assign bypass = 1'b0;
`endif
  assign capture = accept && !bypass;

  assign o_bubble_req = (state_q == ST_FORCE);

  // Pipeline has absolute priority; LU data only uses idle write-port cycles.
  always_comb begin
    o_rf_we    = 1'b0;
    o_rf_rd    = REG_X0;
    o_rf_wdata = '0;
    if (i_pipe_wb_valid) begin
      o_rf_we    = !is_x0(i_pipe_rd);
      o_rf_rd    = i_pipe_rd;
      o_rf_wdata = i_pipe_data;
    end else if (drain) begin
      o_rf_we    = !is_x0(buf_rd_q);
      o_rf_rd    = buf_rd_q;
      o_rf_wdata = buf_data_q;
    end else if (bypass) begin
      o_rf_we    = !is_x0(i_lu_rd);
      o_rf_rd    = i_lu_rd;
      o_rf_wdata = i_lu_data;
    end
  end

  // Buffer state, starvation counter and the one-entry result buffer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      buf_rd_q   <= REG_X0;
      buf_data_q <= '0;
    end else begin
      if (capture) begin
        buf_rd_q   <= i_lu_rd;
        buf_data_q <= i_lu_data;
      end
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (capture) state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (drain) begin
            cnt_q   <= '0;
            state_q <= capture ? ST_HOLD : ST_IDLE;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_W'(STARVE_LIMIT - 1)) state_q <= ST_FORCE;
          end
        end
        ST_FORCE: begin
          if (drain) begin
            cnt_q   <= '0;
            state_q <= capture ? ST_HOLD : ST_IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  riscv_wb_scoreboard #(
    .N_REG(N_REG)
  ) u_sb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_set_en  (i_lu_issue),
    .i_set_idx (i_lu_issue_rd),
    .i_clr_en  (drain || bypass),
    .i_clr_idx (drain ? buf_rd_q : i_lu_rd),
    .i_rs1_d   (i_rs1_d),
    .i_rs2_d   (i_rs2_d),
    .i_rd_d    (i_rd_d),
    .o_stall_d (o_stall_d)
  );

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Vector-table bench for riscv_wb_arbiter with a register-file write scoreboard.
module tb_riscv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_v;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_v;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic [4:0]  rs1, rs2, rdd;
  logic        stall, bubble, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  riscv_wb_arbiter u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pipe_wb_valid (pipe_v),
    .i_pipe_rd       (pipe_rd),
    .i_pipe_data     (pipe_data),
    .i_lu_issue      (lu_issue),
    .i_lu_issue_rd   (lu_issue_rd),
    .i_lu_valid      (lu_v),
    .o_lu_ready      (lu_ready),
    .i_lu_rd         (lu_rd),
    .i_lu_data       (lu_data),
    .i_rs1_d         (rs1),
    .i_rs2_d         (rs2),
    .i_rd_d          (rdd),
    .o_stall_d       (stall),
    .o_bubble_req    (bubble),
    .o_rf_we         (rf_we),
    .o_rf_rd         (rf_rd),
    .o_rf_wdata      (rf_wdata)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        iss;
    logic [4:0]  ird;
    logic        luv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic [4:0]  rs1, rs2, rdd;
    logic        e_we;
    logic [4:0]  e_rd;
    logic        e_rdy, e_stall, e_bub;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string name, input logic r, input logic pv, input logic [4:0] prd,
                     input logic [31:0] pdata, input logic iss, input logic [4:0] ird,
                     input logic luv, input logic [4:0] lrd, input logic [31:0] ldata,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                     input logic e_we, input logic [4:0] e_rd, input logic e_rdy,
                     input logic e_stall, input logic e_bub);
    vec_t v;
    v.name = name; v.rst = r; v.pv = pv; v.prd = prd; v.pdata = pdata;
    v.iss = iss; v.ird = ird; v.luv = luv; v.lrd = lrd; v.ldata = ldata;
    v.rs1 = s1; v.rs2 = s2; v.rdd = d;
    v.e_we = e_we; v.e_rd = e_rd; v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_bub = e_bub;
    vecs.push_back(v);
  endtask

  task automatic check_write();
    int idx = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (idx < 0 && exp_q[k].rd == rf_rd) idx = k;
    n_vec++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL rf_write: unexpected write rd=%0d data=%h, required no write", rf_rd, rf_wdata);
    end else begin
      if (rf_wdata !== exp_q[idx].data) begin
        n_bad++;
        $display("FAIL rf_wdata rd=%0d: got %h, required %h", rf_rd, rf_wdata, exp_q[idx].data);
      end
      exp_q.delete(idx);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1; pipe_v = 1'b0; pipe_rd = '0; pipe_data = '0; lu_issue = 1'b0; lu_issue_rd = '0;
    lu_v = 1'b0; lu_rd = '0; lu_data = '0; rs1 = '0; rs2 = '0; rdd = '0;

    //   name      rst pv prd  pdata        iss ird luv lrd ldata         rs1 rs2 rdd  we rd rdy stl bub
    add("reset",   0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         5, 7, 3,   0, 0, 1, 0, 0);
    add("iss5",    0, 0, 0,  32'h0,        1, 5,  0, 0,  32'h0,         0, 0, 0,   0, 0, 1, 0, 0);
    add("raw5",    0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         5, 0, 0,   0, 0, 1, 1, 0);
`ifdef RISCV_WB_LU_BYPASS_EN
    add("acc5",    0, 0, 0,  32'h0,        0, 0,  1, 5,  32'hDEADBEEF,  5, 0, 0,   1, 5, 1, 1, 0);
    add("drn5",    0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         5, 0, 0,   0, 0, 1, 0, 0);
`else
    add("acc5",    0, 0, 0,  32'h0,        0, 0,  1, 5,  32'hDEADBEEF,  5, 0, 0,   0, 0, 1, 1, 0);
    add("drn5",    0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         5, 0, 0,   1, 5, 1, 1, 0);
`endif
    add("clr5",    0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         5, 0, 0,   0, 0, 1, 0, 0);
    add("iss9",    0, 1, 1,  32'h11,       1, 9,  0, 0,  32'h0,         0, 0, 0,   1, 1, 1, 0, 0);
    add("acc9",    0, 1, 2,  32'h22,       0, 0,  1, 9,  32'h99,        0, 9, 0,   1, 2, 1, 1, 0);
    add("blk9a",   0, 1, 3,  32'h33,       0, 0,  0, 0,  32'h0,         0, 9, 0,   1, 3, 0, 1, 0);
    add("blk9b",   0, 1, 4,  32'h44,       0, 0,  0, 0,  32'h0,         0, 9, 0,   1, 4, 0, 1, 0);
    add("drn9",    0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         0, 9, 0,   1, 9, 1, 1, 0);
    add("clr9",    0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         0, 9, 0,   0, 0, 1, 0, 0);
    add("iss12",   0, 0, 0,  32'h0,        1, 12, 0, 0,  32'h0,         0, 0, 12,  0, 0, 1, 0, 0);
    add("acc12",   0, 1, 19, 32'h19,       0, 0,  1, 12, 32'h00C0FFEE,  0, 0, 12,  1, 19, 1, 1, 0);
    for (int k = 1; k <= 6; k++)
      add($sformatf("blk12_%0d", k), 0, 1, 5'(19 + k), 32'(k), 0, 0, (k >= 5) ? 1'b1 : 1'b0,
          13, 32'h13131313, 0, 0, 12, 1, 5'(19 + k), 0, 1, (k >= 4) ? 1'b1 : 1'b0);
    add("drn12",   0, 0, 0,  32'h0,        0, 0,  1, 13, 32'h13131313,  0, 0, 12,  1, 12, 1, 1, 1);
    add("drn13",   0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         0, 0, 12,  1, 13, 1, 0, 0);
    add("idle",    0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         0, 0, 0,   0, 0, 1, 0, 0);
    add("acc0",    0, 0, 0,  32'h0,        0, 0,  1, 0,  32'h1234,      0, 0, 0,   0, 0, 1, 0, 0);
    add("drn0",    0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         0, 0, 0,   0, 0, 1, 0, 0);
    add("pipe0",   0, 1, 0,  32'h5,        0, 0,  0, 0,  32'h0,         0, 0, 0,   0, 0, 1, 0, 0);
    add("iss7",    0, 0, 0,  32'h0,        1, 7,  0, 0,  32'h0,         0, 0, 0,   0, 0, 1, 0, 0);
    add("acc7",    0, 1, 1,  32'h101,      0, 0,  1, 7,  32'h77,        7, 0, 0,   1, 1, 1, 1, 0);
    add("blk7",    0, 1, 2,  32'h202,      0, 0,  0, 0,  32'h0,         7, 0, 0,   1, 2, 0, 1, 0);
    add("rst_mid", 1, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         7, 0, 0,   0, 0, 1, 0, 0);
    add("post1",   0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         7, 0, 0,   0, 0, 1, 0, 0);
    add("post2",   0, 0, 0,  32'h0,        0, 0,  0, 0,  32'h0,         0, 0, 0,   0, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; pipe_v = v.pv; pipe_rd = v.prd; pipe_data = v.pdata;
      lu_issue = v.iss; lu_issue_rd = v.ird; lu_v = v.luv; lu_rd = v.lrd; lu_data = v.ldata;
      rs1 = v.rs1; rs2 = v.rs2; rdd = v.rdd;
      if (v.pv && v.prd != 5'd0) exp_q.push_back({v.prd, v.pdata});
      if (!v.rst && v.luv && v.e_rdy && v.lrd != 5'd0) exp_q.push_back({v.lrd, v.ldata});
      #3;
      n_vec++;
      if (rf_we !== v.e_we || lu_ready !== v.e_rdy || stall !== v.e_stall || bubble !== v.e_bub ||
          (v.e_we && rf_rd !== v.e_rd)) begin
        n_bad++;
        $display("FAIL %s: got we=%b rd=%0d rdy=%b stall=%b bub=%b, required we=%b rd=%0d rdy=%b stall=%b bub=%b",
                 v.name, rf_we, rf_rd, lu_ready, stall, bubble, v.e_we, v.e_rd, v.e_rdy, v.e_stall, v.e_bub);
      end
      if (rf_we === 1'b1) check_write();
      if (pipe_v && pipe_rd != 5'd0 && u_dut.u_sb.mask_q[pipe_rd]) begin
        n_bad++;
        $display("FAIL %s: pipe write to pending rd=%0d, required not pending", v.name, pipe_rd);
      end
      if (v.rst) exp_q.delete();
      @(posedge clk);
      #1;
    end

    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_writes: %0d expected writes never seen, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_wb_arbiter.md
Name: riscv_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback result and one long-latency unit (LU, e.g. mul/div) result.
- Keeps a pending-destination scoreboard for LU instructions and raises decode stalls on RAW/WAW hazards against those destinations.
- Sits between the W-stage result mux output and the register file, beside the hazard unit.

Parameters:
- XLEN, 32, data width; matches the `XLEN define.
- N_REG, 32, number of architectural registers (index width = clog2(N_REG)).
- STARVE_LIMIT, 4, consecutive cycles a buffered LU result may be blocked before a pipeline bubble is requested.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_pipe_wb_valid  input  1  W-stage instruction writes rd this cycle.
- i_pipe_rd  input  5  W-stage destination.
- i_pipe_data  input  XLEN  W-stage result (o_result_w).
- i_lu_issue  input  1  LU instruction leaves decode this cycle.
- i_lu_issue_rd  input  5  its destination.
- i_lu_valid  input  1  LU result available.
- o_lu_ready  output  1  arbiter accepts the LU result; transfer occurs when valid && ready.
- i_lu_rd  input  5  LU result destination.
- i_lu_data  input  XLEN  LU result.
- i_rs1_d, i_rs2_d, i_rd_d  input  5 each  decode-stage register indices.
- o_stall_d  output  1  decode must stall.
- o_bubble_req  output  1  request that the hazard unit inject a W-stage bubble next cycle.
- o_rf_we  output  1  register-file write enable.
- o_rf_rd  output  5  write index.
- o_rf_wdata  output  XLEN  write data.

Behaviour:
- Reset values: scoreboard mask 0, buffer empty, state IDLE, starve counter 0.
  - Outputs after reset: o_lu_ready=1, o_stall_d=0, o_bubble_req=0, o_rf_we=0 when i_pipe_wb_valid=0.
  - Reset mid-operation discards any buffered result and clears all pending bits.
- Write-port priority: the pipeline always wins.
  - o_rf_we = (pipe write with rd≠0) OR buffer drain.
  - A drain happens only in a cycle with i_pipe_wb_valid=0.
  - Writes to x0 are suppressed: o_rf_we=0 for a pipe write with rd=0; a buffered LU result with rd=0 drains without asserting o_rf_we.
- LU path: one-entry buffer, so the LU result reaches the register file at least 1 cycle after acceptance.
  - o_lu_ready = buffer empty OR buffer draining this cycle.
- FSM states:
  - IDLE: buffer empty. On valid&&ready → HOLD.
  - HOLD: buffer full, counter increments each blocked cycle.
    - Drain with no new accept → IDLE.
    - Drain plus new accept → HOLD, counter reset to 0.
    - Counter reaches STARVE_LIMIT-1 while blocked → FORCE.
  - FORCE: o_bubble_req=1. Drain → IDLE (or HOLD if a new result is accepted), counter reset to 0.
- Scoreboard:
  - Bit rd set on i_lu_issue when rd≠0.
  - Bit cleared in the cycle the buffered LU result drains.
  - Same rd set and cleared in one cycle: set wins.
  - Bit 0 is never set.
- o_stall_d (combinational) = mask[rs1_d] | mask[rs2_d] | mask[rd_d], each term qualified by index≠0. The rd term covers WAW.
- Pipe write to a pending rd is illegal. Guaranteed by o_stall_d; the bench asserts it never occurs.

Optional Feature:
- RISCV_WB_LU_BYPASS_EN, defined: in IDLE, when i_lu_valid=1 and i_pipe_wb_valid=0, the LU result writes the register file in the same cycle and clears its scoreboard bit; the buffer stays empty and the state stays IDLE.
- RISCV_WB_LU_BYPASS_EN, undefined: every LU result passes through the buffer; minimum latency is 1 cycle.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=2'd0, HOLD=2'd1, FORCE=2'd2), the register-index width constant, and the x0 index constant.
- One sub-module is natural: riscv_wb_scoreboard, containing the pending mask, set/clear logic and the three hazard lookups.

Test Plan:
- Reset with i_pipe_wb_valid=0 → o_rf_we=0, o_lu_ready=1, o_stall_d=0, mask=0.
- LU issue rd=5; decode rs1=5 → o_stall_d=1. LU result (rd=5, 0xDEADBEEF) accepted with the pipe idle → next cycle o_rf_we=1, rd=5, wdata=0xDEADBEEF; the cycle after, o_stall_d=0. With the macro defined, the write occurs in the acceptance cycle.
- LU result buffered while i_pipe_wb_valid=1 for 3 cycles (STARVE_LIMIT=4) → no bubble; pipe writes win; drain occurs on the first idle cycle.
- Pipe busy 6 cycles with buffer full → o_bubble_req=1 from the 4th blocked cycle until the drain, then 0, state IDLE.
- LU result rd=0, data 0x1234 → o_rf_we never asserted for it; o_lu_ready returns to 1.
- i_rst asserted while the buffer is full and mask[7]=1 → immediately buffer empty, mask=0, o_bubble_req=0, no write of the stale data after release.
